// File: rtl/seq_mult_8bit_pkg.sv
// seq_mult_8bit_pkg: shared ALU constants and multiplier state encoding
package seq_mult_8bit_pkg;
   localparam int WIDTH = 8;
   localparam int CNT_W = 3;
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/seq_mult_8bit_if.sv
// seq_mult_8bit_if: operand/product valid-ready handshake bundle
interface seq_mult_8bit_if;
   import seq_mult_8bit_pkg::*;
   logic in_valid, in_ready, out_valid, out_ready, Z, HI;
   logic [WIDTH-1:0] A, B;
   logic [2*WIDTH-1:0] P;
   modport master (output in_valid, A, B, out_ready, input in_ready, out_valid, P, Z, HI);
   modport slave (input in_valid, A, B, out_ready, output in_ready, out_valid, P, Z, HI);
endinterface

// File: rtl/RippleCarryAdder8Bit.sv
// RippleCarryAdder8Bit: 8-bit ripple-carry adder built from full-adder cells
module RippleCarryAdder8Bit
   import seq_mult_8bit_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   logic [WIDTH:0] c;
   assign c[0] = cin;
   assign cout = c[WIDTH];
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign sum[i] = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
endmodule

// File: rtl/seq_mult_8bit.sv
// seq_mult_8bit: unsigned 8x8 shift-add multiplier reusing one ripple-carry adder over 8 cycles
module seq_mult_8bit
   import seq_mult_8bit_pkg::*;
(
   input logic            clk,
   input logic            rst_n,
   seq_mult_8bit_if.slave bus
);
   state_t state, nxt;
   logic [WIDTH-1:0] mcand, addend, sum;
   logic [2*WIDTH-1:0] acc, acc_nxt, p;
   logic [CNT_W-1:0] cnt;
   logic carry, z, hi, last;
   assign addend = acc[0] ? mcand : '0;
   assign acc_nxt = {carry, sum, acc[WIDTH-1:1]};
   assign last = (state == CALC) && (cnt == '1);
   RippleCarryAdder8Bit u_add (
      .a(acc[2*WIDTH-1:WIDTH]),
      .b(addend),
      .cin(1'b0),
      .sum(sum),
      .cout(carry)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   always_comb
      nxt = (state == IDLE) ? (bus.in_valid ? CALC : IDLE) :
            (state == CALC) ? (cnt == '1 ? DONE : CALC) :
            (bus.out_ready ? IDLE : DONE);
   always_comb begin
      bus.in_ready = state == IDLE;
      bus.out_valid = state == DONE;
   end
   // Result flags live in their own registers so they read 0 out of reset and hold across the next operation
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mcand <= '0;
         acc <= '0;
         cnt <= '0;
         p <= '0;
         z <= 1'b0;
         hi <= 1'b0;
      end else if (state == IDLE && bus.in_valid) begin
         mcand <= bus.A;
         acc <= {{WIDTH{1'b0}}, bus.B};
         cnt <= '0;
      end else if (state == CALC) begin
         acc <= acc_nxt;
         cnt <= cnt + 1'b1;
         if (last) begin
            p <= acc_nxt;
            z <= acc_nxt == '0;
            hi <= |acc_nxt[2*WIDTH-1:WIDTH];
         end
      end
   assign bus.P = p;
   assign bus.Z = z;
   assign bus.HI = hi;
endmodule
